// File: rtl/light_pkg.sv
// Shared types and default sizing for the light level controller.
package light_pkg;

  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_LEVEL_W    = 3;
  localparam int DEF_MIN_LEVEL  = 0;
  localparam int DEF_MAX_LEVEL  = 4;
  localparam int DEF_INIT_LEVEL = 2;

  typedef logic [DEF_LEVEL_W-1:0] level_t;

  typedef enum logic {
    DIR_DOWN,
    DIR_UP
  } dir_e;

endpackage

// File: rtl/light_level_chan.sv
// One light channel: edge detect, hold/repeat stepping, saturating level.
// Idle auto-dim counter present only when LIGHT_AUTODIM_EN is defined.
module light_level_chan
  import light_pkg::*;
#(
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int MIN_LEVEL     = DEF_MIN_LEVEL,
  parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
  parameter int INIT_LEVEL    = DEF_INIT_LEVEL,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
`ifdef LIGHT_AUTODIM_EN
  ,
  parameter int IDLE_CYCLES   = 64
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               on,
  input  logic               up,
  input  logic               down,
  output logic [LEVEL_W-1:0] level
);

  localparam int CMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [LEVEL_W-1:0] LMIN =
    LEVEL_W'(MIN_LEVEL);
  localparam logic [LEVEL_W-1:0] LMAX =
    LEVEL_W'(MAX_LEVEL);
  localparam logic [CW-1:0] CHOLD =
    CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CREP =
    CW'(REPEAT_CYCLES);

  logic               req;
  dir_e               dir;
  logic               first;
  logic               step;
  logic               prev_req_q;
  logic               prev_req_d;
  dir_e               prev_dir_q;
  dir_e               prev_dir_d;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               rep_q;
  logic               rep_d;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;

  always_comb begin
    req   = up ^ down;
    dir   = up ? DIR_UP : DIR_DOWN;
    first = req &&
            (!prev_req_q || prev_dir_q != dir);
    prev_req_d = req;
    prev_dir_d = dir;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    step    = 1'b0;
    level_d = level_q;
    // cnt_q == 0 means no press is being tracked
    if (!on || !req) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (first) begin
      step  = 1'b1;
      cnt_d = CW'(1);
      rep_d = 1'b0;
    end else if (cnt_q != '0) begin
      if (cnt_q == (rep_q ? CREP : CHOLD)) begin
        step  = 1'b1;
        cnt_d = CW'(1);
        rep_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (step) begin
      unique case (1'b1)
        (dir == DIR_UP && level_q != LMAX):
          level_d = level_q + LEVEL_W'(1);
        (dir == DIR_DOWN && level_q != LMIN):
          level_d = level_q - LEVEL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

`ifdef LIGHT_AUTODIM_EN
  localparam int IW = $clog2(IDLE_CYCLES);

  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_d;
  logic [LEVEL_W-1:0] dim_level;

  // any request clears idle, so user steps always win
  always_comb begin
    idle_d    = idle_q + IW'(1);
    dim_level = level_d;
    if (!on || req) begin
      idle_d = '0;
    end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
      idle_d = '0;
      if (level_q != LMIN)
        dim_level = level_q - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_req_q <= 1'b0;
      prev_dir_q <= DIR_DOWN;
      cnt_q      <= '0;
      rep_q      <= 1'b0;
      level_q    <= LEVEL_W'(INIT_LEVEL);
    end else begin
      prev_req_q <= prev_req_d;
      prev_dir_q <= prev_dir_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
`ifdef LIGHT_AUTODIM_EN
      level_q    <= dim_level;
`else
      level_q    <= level_d;
`endif
    end
  end

  assign level = level_q;

endmodule

// File: rtl/light_level_ctrl.sv
// Multi-channel brightness controller with shared-phase PWM outputs.
// Optional idle auto-dim enabled by defining LIGHT_AUTODIM_EN.
module light_level_ctrl
  import light_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int MIN_LEVEL     = DEF_MIN_LEVEL,
  parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
  parameter int INIT_LEVEL    = DEF_INIT_LEVEL,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
`ifdef LIGHT_AUTODIM_EN
  ,
  parameter int IDLE_CYCLES   = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        on,
  input  logic [CHANNELS-1:0]         up_count,
  input  logic [CHANNELS-1:0]         down_count,
  output logic [CHANNELS*LEVEL_W-1:0] level,
  output logic [CHANNELS-1:0]         at_max,
  output logic [CHANNELS-1:0]         at_min,
  output logic [CHANNELS-1:0]         pwm_out
);

  logic [LEVEL_W-1:0]  lvl [CHANNELS];
  logic [LEVEL_W-1:0]  phase_q;
  logic [LEVEL_W-1:0]  phase_d;
  logic [CHANNELS-1:0] pwm_q;
  logic [CHANNELS-1:0] pwm_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    light_level_chan #(
      .LEVEL_W       (LEVEL_W),
      .MIN_LEVEL     (MIN_LEVEL),
      .MAX_LEVEL     (MAX_LEVEL),
      .INIT_LEVEL    (INIT_LEVEL),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
`ifdef LIGHT_AUTODIM_EN
      ,
      .IDLE_CYCLES   (IDLE_CYCLES)
`endif
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .on    (on),
      .up    (up_count[i]),
      .down  (down_count[i]),
      .level (lvl[i])
    );

    assign level[i*LEVEL_W +: LEVEL_W] = lvl[i];
    assign at_max[i] =
      (lvl[i] == LEVEL_W'(MAX_LEVEL));
    assign at_min[i] =
      (lvl[i] == LEVEL_W'(MIN_LEVEL));
  end

  // phase free-runs so PWM stays aligned across on toggles
  always_comb begin
    if (phase_q == LEVEL_W'(MAX_LEVEL - 1))
      phase_d = '0;
    else
      phase_d = phase_q + LEVEL_W'(1);
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = on & (phase_q < lvl[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      pwm_q   <= '0;
    end else begin
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_light_level_ctrl.sv
// Directed self-checking bench for light_level_ctrl (default build).
module tb_light_level_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        on = 1'b0;
  logic [3:0]  up_count = '0;
  logic [3:0]  down_count = '0;
  logic [11:0] level;
  logic [3:0]  at_max;
  logic [3:0]  at_min;
  logic [3:0]  pwm_out;

  int n_cmp = 0;
  int n_bad = 0;
  int hi;
  int e;

  light_level_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .on         (on),
    .up_count   (up_count),
    .down_count (down_count),
    .level      (level),
    .at_max     (at_max),
    .at_min     (at_min),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] lv(int ch);
    return level[ch*3 +: 3];
  endfunction

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] u,
                       logic [3:0] d);
    up_count   = u;
    down_count = d;
    cyc();
  endtask

  task automatic pulse(logic [3:0] u,
                       logic [3:0] d);
    drive(u, d);
    drive(4'h0, 4'h0);
  endtask

  task automatic pwm_hi(int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      c += int'(pwm_out[3]);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    on = 1'b1;
    #20;
    for (int c = 0; c < 4; c++)
      chk($sformatf("rst_lvl%0d", c), lv(c), 2);
    chk("rst_at_max", at_max, 0);
    chk("rst_at_min", at_min, 0);
    chk("rst_pwm", pwm_out, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_lvl0", lv(0), 2);

    for (int k = 0; k < 3; k++) begin
      pulse(4'h1, 4'h0);
      e = (k + 3 > 4) ? 4 : k + 3;
      chk($sformatf("ch0_up%0d", k), lv(0), e);
    end
    chk("ch0_at_max", at_max[0], 1);
    for (int k = 0; k < 5; k++) begin
      pulse(4'h0, 4'h1);
      e = (3 - k < 0) ? 0 : 3 - k;
      chk($sformatf("ch0_dn%0d", k), lv(0), e);
    end
    chk("ch0_at_min", at_min[0], 1);
    chk("ch0_not_max", at_max[0], 0);

    pulse(4'h0, 4'h2);
    pulse(4'h0, 4'h2);
    chk("ch1_zero", lv(1), 0);
    for (int j = 0; j < 20; j++) begin
      drive(4'h2, 4'h0);
      e = 1 + int'(j >= 8) + int'(j >= 12)
            + int'(j >= 16);
      chk($sformatf("ch1_hold%0d", j), lv(1), e);
    end
    drive(4'h0, 4'h0);
    chk("ch1_at_max", at_max[1], 1);

    repeat (10) drive(4'h4, 4'h4);
    chk("ch2_both", lv(2), 2);
    drive(4'h0, 4'h0);
    on = 1'b0;
    cyc();
    pulse(4'h4, 4'h0);
    chk("ch2_off_lvl", lv(2), 2);
    chk("off_pwm", pwm_out, 0);
    repeat (3) drive(4'h4, 4'h0);
    on = 1'b1;
    repeat (12) drive(4'h4, 4'h0);
    chk("ch2_on_held", lv(2), 2);
    chk("ch1_pwm_on", pwm_out[1], 1);
    drive(4'h0, 4'h0);

    pulse(4'h0, 4'h8);
    chk("ch3_lvl1", lv(3), 1);
    pwm_hi(8, hi);
    chk("pwm_lvl1", hi, 2);
    repeat (3) pulse(4'h8, 4'h0);
    chk("ch3_lvl4", lv(3), 4);
    pwm_hi(8, hi);
    chk("pwm_lvl4", hi, 8);
    repeat (4) pulse(4'h0, 4'h8);
    chk("ch3_lvl0", lv(3), 0);
    pwm_hi(8, hi);
    chk("pwm_lvl0", hi, 0);
    drive(4'h8, 4'h0);
    chk("lat_up_lvl", lv(3), 1);
    chk("lat_up_pwm", pwm_out[3], 0);
    drive(4'h0, 4'h0);
    repeat (3) pulse(4'h8, 4'h0);
    cyc();
    drive(4'h0, 4'h8);
    chk("lat_dn_lvl", lv(3), 3);
    chk("lat_dn_pwm", pwm_out[3], 1);
    drive(4'h0, 4'h0);

    for (int j = 0; j < 13; j++)
      drive(4'h1, 4'h0);
    chk("ch0_midhold", lv(0), 3);
    #3 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++)
      chk($sformatf("arst_lvl%0d", c), lv(c), 2);
    chk("arst_pwm", pwm_out, 0);
    chk("arst_at_max", at_max, 0);
    up_count = 4'h0;
    #10 rst_n = 1'b1;
    repeat (3) cyc();
    for (int c = 0; c < 4; c++)
      chk($sformatf("rel_lvl%0d", c), lv(c), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
